// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer, and a saturating back-pressure counter.
// Payload is opaque: bits pass through unmodified in strict FIFO order.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Main entry feeds the output; skid entry catches the word that arrives
    // while the main entry is stalled, so upstream ready can be registered.
    logic              main_vld_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic              skid_vld_p0;
    logic [DATA_W-1:0] skid_data_p0;
    logic [CNT_W-1:0]  stall_cnt_p0;

    logic in_fire;
    logic out_fire;
    logic stall;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // With the skid buffer, ready depends only on a flop; without it, a full
    // stage may still accept when downstream drains in the same cycle.
    assign in_ready_o = (SKID != 0) ? !skid_vld_p0 : (!main_vld_p0 | out_ready_i);

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = main_vld_p0 & out_ready_i;
    assign stall       = main_vld_p0 & !out_ready_i;

    assign out_valid_o = main_vld_p0;
    assign out_data_o  = main_data_p0;
    assign occupancy_o = {1'b0, main_vld_p0} + {1'b0, skid_vld_p0};
    assign stall_cnt_o = stall_cnt_p0;

    // Entry state: flush kills both entries (data left as don't-care),
    // otherwise advance the EMPTY/ONE/FULL occupancy machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_p0  <= 1'b0;
            skid_vld_p0  <= 1'b0;
            main_data_p0 <= '0;
            skid_data_p0 <= '0;
        end else if (flush_i) begin
            main_vld_p0 <= 1'b0;
            skid_vld_p0 <= 1'b0;
        end else if (SKID != 0) begin
            if (!main_vld_p0) begin
                // EMPTY
                if (in_fire) begin
                    main_vld_p0  <= 1'b1;
                    main_data_p0 <= in_data_i;
                end
            end else if (!skid_vld_p0) begin
                // ONE
                if (in_fire && !out_fire) begin
                    skid_vld_p0  <= 1'b1;
                    skid_data_p0 <= in_data_i;
                end else if (in_fire && out_fire) begin
                    main_data_p0 <= in_data_i;
                end else if (out_fire) begin
                    main_vld_p0 <= 1'b0;
                end
            end else begin
                // FULL: ready is low, only the drain side can move
                if (out_fire) begin
                    main_data_p0 <= skid_data_p0;
                    skid_vld_p0  <= 1'b0;
                end
            end
        end else begin
            if (in_fire) begin
                main_vld_p0  <= 1'b1;
                main_data_p0 <= in_data_i;
            end else if (out_fire) begin
                main_vld_p0 <= 1'b0;
            end
        end
    end

    // Back-pressure counter: clear beats increment; flush has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p0 <= '0;
        end else if (clr_cnt_i) begin
            stall_cnt_p0 <= '0;
        end else if (stall) begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: three instances (skid 64-bit, skid with
// a 2-bit counter, no-skid) with per-instance expected-payload queues.
module tb_pipe_stage_skid;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    // Instance 1: SKID=1, DATA_W=64, CNT_W=16
    logic        flush1, v1, r1, clr1;
    logic [63:0] d1;
    logic        rdy1, ov1;
    logic [63:0] od1;
    logic [1:0]  occ1;
    logic [15:0] cnt1;

    // Instance 2: SKID=1, DATA_W=8, CNT_W=2
    logic        flush2, v2, r2, clr2;
    logic [7:0]  d2;
    logic        rdy2, ov2;
    logic [7:0]  od2;
    logic [1:0]  occ2;
    logic [1:0]  cnt2;

    // Instance 3: SKID=0, DATA_W=8, CNT_W=16
    logic        flush3, v3, r3, clr3;
    logic [7:0]  d3;
    logic        rdy3, ov3;
    logic [7:0]  od3;
    logic [1:0]  occ3;
    logic [15:0] cnt3;

    logic [63:0] q1[$];
    logic [7:0]  q2[$];
    logic [7:0]  q3[$];

    pipe_stage_skid #(.DATA_W(64), .SKID(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush1),
        .in_valid_i(v1), .in_ready_o(rdy1), .in_data_i(d1),
        .out_valid_o(ov1), .out_ready_i(r1), .out_data_o(od1),
        .occupancy_o(occ1), .clr_cnt_i(clr1), .stall_cnt_o(cnt1)
    );

    pipe_stage_skid #(.DATA_W(8), .SKID(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush2),
        .in_valid_i(v2), .in_ready_o(rdy2), .in_data_i(d2),
        .out_valid_o(ov2), .out_ready_i(r2), .out_data_o(od2),
        .occupancy_o(occ2), .clr_cnt_i(clr2), .stall_cnt_o(cnt2)
    );

    pipe_stage_skid #(.DATA_W(8), .SKID(0), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush3),
        .in_valid_i(v3), .in_ready_o(rdy3), .in_data_i(d3),
        .out_valid_o(ov3), .out_ready_i(r3), .out_data_o(od3),
        .occupancy_o(occ3), .clr_cnt_i(clr3), .stall_cnt_o(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: on each output transfer, pop the next expected payload.
    always @(negedge clk) begin
        if (rst_n && ov1 && r1) begin
            if (q1.size() == 0) begin
                check("u1 unexpected output", od1, 64'hDEAD);
            end else begin
                check("u1 out data", od1, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov2 && r2) begin
            if (q2.size() == 0) begin
                check("u2 unexpected output", {56'd0, od2}, 64'hDEAD);
            end else begin
                check("u2 out data", {56'd0, od2}, {56'd0, q2.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov3 && r3) begin
            if (q3.size() == 0) begin
                check("u3 unexpected output", {56'd0, od3}, 64'hDEAD);
            end else begin
                check("u3 out data", {56'd0, od3}, {56'd0, q3.pop_front()});
            end
        end
    end

    initial begin
        int exp_cnt2[5] = '{1, 2, 3, 3, 3};
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        flush1 = 0; v1 = 0; r1 = 0; clr1 = 0; d1 = '0;
        flush2 = 0; v2 = 0; r2 = 0; clr2 = 0; d2 = '0;
        flush3 = 0; v3 = 0; r3 = 0; clr3 = 0; d3 = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {63'd0, ov1}, 64'd0);
        check("reset out_data", od1, 64'd0);
        check("reset in_ready", {63'd0, rdy1}, 64'd1);
        check("reset occupancy", {62'd0, occ1}, 64'd0);
        check("reset stall_cnt", {48'd0, cnt1}, 64'd0);
        rst_n = 1'b1;
        tick;
        check("post-reset occupancy", {62'd0, occ1}, 64'd0);
        check("post-reset in_ready", {63'd0, rdy1}, 64'd1);

        // Streaming with downstream always ready
        r1 = 1; v1 = 1; d1 = 64'h1;
        q1.push_back(64'h1); q1.push_back(64'h2);
        q1.push_back(64'h3); q1.push_back(64'h4);
        for (int i = 2; i <= 4; i++) begin
            tick;
            check("stream out_data", od1, 64'(i - 1));
            check("stream occupancy", {62'd0, occ1}, 64'd1);
            d1 = 64'(i);
        end
        tick;
        check("stream last data", od1, 64'h4);
        v1 = 0;
        tick;
        check("stream drained occ", {62'd0, occ1}, 64'd0);
        check("stream no stalls", {48'd0, cnt1}, 64'd0);

        // Back-pressure fill into skid, then drain
        r1 = 0; v1 = 1; d1 = 64'hA;
        q1.push_back(64'hA); q1.push_back(64'hB); q1.push_back(64'hC);
        tick;
        check("fill occ one", {62'd0, occ1}, 64'd1);
        check("fill ready one", {63'd0, rdy1}, 64'd1);
        check("fill cnt0", {48'd0, cnt1}, 64'd0);
        d1 = 64'hB;
        tick;
        check("full occ", {62'd0, occ1}, 64'd2);
        check("full ready", {63'd0, rdy1}, 64'd0);
        check("full cnt1", {48'd0, cnt1}, 64'd1);
        check("full head data", od1, 64'hA);
        d1 = 64'hC;
        tick;
        check("full cnt2", {48'd0, cnt1}, 64'd2);
        check("full occ hold", {62'd0, occ1}, 64'd2);
        check("full head stable", od1, 64'hA);
        tick;
        check("full cnt3", {48'd0, cnt1}, 64'd3);
        r1 = 1;
        tick;
        check("drain occ", {62'd0, occ1}, 64'd1);
        check("drain head B", od1, 64'hB);
        check("drain ready", {63'd0, rdy1}, 64'd1);
        check("drain cnt held", {48'd0, cnt1}, 64'd3);
        tick;
        check("drain head C", od1, 64'hC);
        check("drain occ C", {62'd0, occ1}, 64'd1);
        v1 = 0;
        tick;
        check("drain empty", {62'd0, occ1}, 64'd0);

        // Flush from FULL with simultaneous offer and counter clear
        r1 = 0; v1 = 1; d1 = 64'hA;
        tick;
        d1 = 64'hB;
        tick;
        check("pre-flush occ", {62'd0, occ1}, 64'd2);
        check("pre-flush cnt", {48'd0, cnt1}, 64'd4);
        flush1 = 1; clr1 = 1; d1 = 64'hD;
        tick;
        check("flush out_valid", {63'd0, ov1}, 64'd0);
        check("flush occ", {62'd0, occ1}, 64'd0);
        check("clr wins cnt", {48'd0, cnt1}, 64'd0);
        check("flush ready", {63'd0, rdy1}, 64'd1);
        clr1 = 0;
        tick;
        check("flush drops accept", {63'd0, ov1}, 64'd0);
        check("flush drops occ", {62'd0, occ1}, 64'd0);
        flush1 = 0; r1 = 1; d1 = 64'hFEDC_BA98_7654_3210;
        q1.push_back(64'hFEDC_BA98_7654_3210);
        tick;
        check("post-flush data", od1, 64'hFEDC_BA98_7654_3210);
        v1 = 0;
        tick;
        check("post-flush empty", {62'd0, occ1}, 64'd0);

        // Counter saturation on the 2-bit instance
        v2 = 1; d2 = 8'h5A; r2 = 0;
        q2.push_back(8'h5A);
        tick;
        check("sat cnt start", {62'd0, cnt2}, 64'd0);
        v2 = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("sat cnt", {62'd0, cnt2}, 64'(exp_cnt2[k]));
        end
        clr2 = 1;
        tick;
        check("sat clr", {62'd0, cnt2}, 64'd0);
        clr2 = 0;
        tick;
        check("sat after clr", {62'd0, cnt2}, 64'd1);
        r2 = 1;
        tick;
        check("sat drained", {62'd0, occ2}, 64'd0);

        // No-skid instance: combinational ready
        v3 = 1; d3 = 8'h5; r3 = 0;
        q3.push_back(8'h5); q3.push_back(8'h6);
        #1;
        check("ns ready empty", {63'd0, rdy3}, 64'd1);
        tick;
        d3 = 8'h6;
        #1;
        check("ns ready full", {63'd0, rdy3}, 64'd0);
        check("ns occ", {62'd0, occ3}, 64'd1);
        r3 = 1;
        #1;
        check("ns ready follows", {63'd0, rdy3}, 64'd1);
        tick;
        check("ns data 6", {56'd0, od3}, 64'h6);
        v3 = 0; r3 = 0;
        #1;
        check("ns ready low", {63'd0, rdy3}, 64'd0);
        tick;
        check("ns hold 6", {56'd0, od3}, 64'h6);
        check("ns hold valid", {63'd0, ov3}, 64'd1);
        r3 = 1;
        tick;
        check("ns empty", {62'd0, occ3}, 64'd0);
        check("ns ready empty end", {63'd0, rdy3}, 64'd1);

        tick;
        check("u1 queue drained", 64'(q1.size()), 64'd0);
        check("u2 queue drained", 64'(q2.size()), 64'd0);
        check("u3 queue drained", 64'(q3.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
